// File: rtl/instruction_sequencer_pkg.sv
// Shared opcode, state, fault and decode definitions for the instruction sequencer.
package instruction_sequencer_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_ADVANCE,
    S_STEP_WAIT,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_e;

  typedef struct packed {
    logic is_alu;
    logic is_halt;
    logic is_illegal;
  } decode_t;

endpackage

// File: rtl/instruction_sequencer_decoder.sv
// Combinational opcode classifier: exactly one of is_alu / is_halt / is_illegal is set.
module opcode_decoder
  import instruction_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    if (opcode <= OP_DIV) begin
      dec.is_alu = 1'b1;
    end else if (opcode == OP_HALT) begin
      dec.is_halt = 1'b1;
    end else begin
      dec.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: owns the PC, issues one ALU op per instruction
// with a start/done handshake, and handles step mode, wrap/halt and ALU timeout.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 8,
  parameter int LAST_ADDR   = 5,
  parameter int WRAP        = 0,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   alu_done,
  output logic [PC_WIDTH-1:0]    program_counter,
  output logic [3:0]             alu_op,
  output logic [3:0]             alu_operand,
  output logic                   alu_start,
  output logic                   busy,
  output logic                   halted,
  output logic [1:0]             fault,
  output logic [7:0]             instr_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [3:0]             alu_op_q, alu_op_d;
  logic [3:0]             alu_operand_q, alu_operand_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  fault_e                 fault_q, fault_d;
  logic [7:0]             count_q, count_d;
  decode_t                dec;

  opcode_decoder u_decoder (
    .opcode (ir_q[INSTR_WIDTH-1 -: 4]),
    .dec    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE_RST;
      pc_q          <= '0;
      ir_q          <= '0;
      alu_op_q      <= '0;
      alu_operand_q <= '0;
      timer_q       <= '0;
      fault_q       <= FAULT_NONE;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      alu_op_q      <= alu_op_d;
      alu_operand_q <= alu_operand_d;
      timer_q       <= timer_d;
      fault_q       <= fault_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_op_d      = alu_op_q;
    alu_operand_d = alu_operand_q;
    timer_d       = timer_q;
    fault_d       = fault_q;
    count_d       = count_q;
    case (state_q)
      S_IDLE_RST, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          fault_d = FAULT_NONE;
          count_d = '0;
        end
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Operation is latched here so it is already valid alongside alu_start.
        if (dec.is_alu) begin
          alu_op_d      = ir_q[INSTR_WIDTH-1 -: 4];
          alu_operand_d = ir_q[3:0];
          state_d       = S_EXEC;
        end else if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          fault_d = FAULT_ILLEGAL;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the final timeout cycle still retires the instruction.
        if (alu_done) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          state_d = S_ADVANCE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          fault_d = FAULT_TIMEOUT;
          state_d = S_HALT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ADVANCE: begin
        if ((pc_q == PC_WIDTH'(LAST_ADDR)) && (WRAP == 0)) begin
          state_d = S_HALT;
        end else begin
          pc_d    = (pc_q == PC_WIDTH'(LAST_ADDR)) ? '0 : pc_q + PC_WIDTH'(1);
          state_d = step_mode ? S_STEP_WAIT : S_FETCH;
        end
      end
      S_STEP_WAIT: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE_RST;
    endcase
  end

  assign program_counter = pc_q;
  assign alu_op          = alu_op_q;
  assign alu_operand     = alu_operand_q;
  assign alu_start       = (state_q == S_EXEC);
  assign busy            = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                           (state_q == S_EXEC)  || (state_q == S_WAIT)   ||
                           (state_q == S_ADVANCE);
  assign halted          = (state_q == S_HALT);
  assign fault           = fault_q;
  assign instr_count     = count_q;

endmodule
